// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - shared register map, STATUS layout and shifter states for mmio_uart_tx
// Register offsets decode mem_addr[3:2]. STATUS packs full/empty/count in the low byte and busy in bit 31.
package mmio_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IRQCTL = 2'd3;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_COUNT_LSB = 2;
  localparam int STAT_COUNT_W   = 6;
  localparam int STAT_BUSY_BIT  = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] status_word(input logic busy, input logic [5:0] count,
                                              input logic empty, input logic full);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    w[STAT_BUSY_BIT]  = busy;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_fifo.sv
// rtl/mmio_uart_fifo.sv - byte FIFO with wrap-around pointers feeding the UART shifter
// Pointers carry one extra wrap bit so full and empty are distinguishable. A push on a full FIFO is
// honoured only when a pop happens in the same cycle. The head entry is visible on pop_data.
module mmio_uart_fifo
  import mmio_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en, rd_en;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Qualify requests and advance the pointers.
  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q + (wr_en ? 1'b1 : 1'b0);
    rd_ptr_d = rd_ptr_q + (rd_en ? 1'b1 : 1'b0);
  end

  // Pointer registers; clearing them discards any stored bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and baud divisor
// Optional interrupt output and IRQCTL register are built when MMIO_UART_TX_IRQ_EN is defined.
// Each bit lasts max(DIV,1) cycles; the divisor is sampled at every bit boundary.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        hold_q, hold_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [AW:0] fifo_count;
  logic [6:0]  count_ext;
  logic        busy, is_write, is_push, accept;
  logic [15:0] period_m1;
  logic        irq_en;
  logic        unused_bits;

  assign busy      = (state_q != ST_IDLE);
  assign period_m1 = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign count_ext = 7'(fifo_count);
  assign is_write  = |mem_wstrb;
  assign is_push   = (mem_addr[3:2] == REG_TXDATA) && mem_wstrb[0];
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], count_ext[6]};

  mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (mem_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Shifter state register with its bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: a pop from IDLE or at the end of STOP starts the next frame directly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = period_m1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          cnt_d     = period_m1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = period_m1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            cnt_d    = period_m1;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Serial line decode from the current state; idle and stop are high.
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shift_q[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  // Bus handshake and register file: a full-FIFO push waits unless a pop frees a slot this cycle,
  // and a request still held after its strobe is locked out until mem_valid drops.
  always_comb begin
    accept      = mem_valid && !mem_ready_q && !hold_q && (!is_push || !fifo_full || fifo_pop);
    fifo_push   = accept && is_push;
    mem_ready_d = accept;
    hold_d      = mem_valid && (mem_ready_q || hold_q);
    div_d       = div_q;
    mem_rdata_d = '0;
    if (accept && is_write && (mem_addr[3:2] == REG_DIV)) begin
      if (mem_wstrb[0]) div_d[7:0]  = mem_wdata[7:0];
      if (mem_wstrb[1]) div_d[15:8] = mem_wdata[15:8];
    end
    if (accept && !is_write) begin
      case (mem_addr[3:2])
        REG_STATUS: mem_rdata_d = status_word(busy, count_ext[5:0], fifo_empty, fifo_full);
        REG_DIV:    mem_rdata_d = {16'd0, div_q};
        REG_IRQCTL: mem_rdata_d = {31'd0, irq_en};
        default:    mem_rdata_d = '0;
      endcase
    end
  end

  // Bus-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      hold_q      <= 1'b0;
      div_q       <= DIV_RESET;
    end else begin
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      hold_q      <= hold_d;
      div_q       <= div_d;
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  assign irq_en = irq_en_q;
  assign irq    = irq_q;

  // Interrupt enable register and the registered "all sent" condition.
  always_comb begin
    irq_en_d = irq_en_q;
    if (accept && is_write && (mem_addr[3:2] == REG_IRQCTL) && mem_wstrb[0]) irq_en_d = mem_wdata[0];
    irq_d = irq_en_q && fifo_empty && !busy;
  end

  // Interrupt flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx (register table, frames, stall, reset, irq)
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX  = 32'h2000_0000;
  localparam logic [31:0] A_ST  = 32'h2000_0004;
  localparam logic [31:0] A_DIV = 32'h2000_0008;
  localparam logic [31:0] A_IRQ = 32'h2000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_tx;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        irq;
`endif

  mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .uart_tx   (uart_tx)
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb_q[$];
  int         starts[$];
  int         cur_div = 16;
  bit         mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Line monitor: decodes frames at bit centres and compares against the scoreboard queue.
  int         mst = 0;
  int         mt = 0;
  logic [7:0] mbyte = '0;
  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      mst = 0;
    end else if (mst == 0) begin
      if (uart_tx === 1'b0) begin
        mst = 1;
        mt  = 0;
        starts.push_back(cyc);
      end
    end else begin
      mt++;
      if (mt >= cur_div/2 + cur_div && mt <= cur_div/2 + 8*cur_div && ((mt - cur_div/2) % cur_div) == 0)
        mbyte[(mt - cur_div/2)/cur_div - 1] = uart_tx;
      if (mt == cur_div/2 + 9*cur_div) begin
        check("stop_bit", {31'd0, uart_tx}, 32'd1);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=0x%02h expected=none", mbyte);
        end else begin
          check("frame_byte", {24'd0, mbyte}, {24'd0, sb_q.pop_front()});
        end
        mst = 0;
      end
    end
  end

  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int lat);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (mem_ready !== 1'b1 && lat < 3000);
    if (mem_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL bus_timeout actual=no_ready expected=ready addr=0x%08h", a);
    end
    rd = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size(), 0);
    repeat (cur_div + 2) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    int          lat;
    int          pulses;
    int          stall_cyc;
    logic [31:0] irq_exp;
    logic [7:0]  b;

`ifdef MMIO_UART_TX_IRQ_EN
    irq_exp = 32'd1;
`else
    irq_exp = 32'd0;
`endif
    vecs.push_back('{A_ST,  32'h0,         4'b0000, 1, 32'h0000_0002});
    vecs.push_back('{A_DIV, 32'h0,         4'b0000, 1, 32'h0000_0010});
    vecs.push_back('{A_DIV, 32'h0000_1234, 4'b0011, 0, 32'h0});
    vecs.push_back('{A_DIV, 32'h0,         4'b0000, 1, 32'h0000_1234});
    vecs.push_back('{A_DIV, 32'h0000_ABCD, 4'b0001, 0, 32'h0});
    vecs.push_back('{A_DIV, 32'h0,         4'b0000, 1, 32'h0000_12CD});
    vecs.push_back('{A_DIV, 32'hFFFF_5600, 4'b0010, 0, 32'h0});
    vecs.push_back('{A_DIV, 32'h0,         4'b0000, 1, 32'h0000_56CD});
    vecs.push_back('{A_DIV, 32'hFFFF_FFFF, 4'b1100, 0, 32'h0});
    vecs.push_back('{A_DIV, 32'h0,         4'b0000, 1, 32'h0000_56CD});
    vecs.push_back('{A_TX,  32'h0,         4'b0000, 1, 32'h0000_0000});
    vecs.push_back('{A_ST,  32'hFFFF_FFFF, 4'b1111, 0, 32'h0});
    vecs.push_back('{A_TX,  32'h0000_0077, 4'b1110, 0, 32'h0});
    vecs.push_back('{A_ST,  32'h0,         4'b0000, 1, 32'h0000_0002});
    vecs.push_back('{A_IRQ, 32'h0000_0001, 4'b0001, 0, 32'h0});
    vecs.push_back('{A_IRQ, 32'h0,         4'b0000, 1, irq_exp});
    vecs.push_back('{A_IRQ, 32'h0000_0000, 4'b0001, 0, 32'h0});
    vecs.push_back('{A_IRQ, 32'h0,         4'b0000, 1, 32'h0});
    vecs.push_back('{A_DIV, 32'h0000_0004, 4'b0011, 0, 32'h0});
    vecs.push_back('{A_DIV, 32'h0,         4'b0000, 1, 32'h0000_0004});

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Held mem_valid on a DIV read gives a single strobe.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = A_DIV;
    mem_wstrb = 4'b0000;
    pulses = 0;
    rd = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        pulses++;
        rd = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    check("held_valid_pulses", pulses, 1);
    check("held_valid_rdata", rd, 32'h0000_0010);

    // Register table.
    foreach (vecs[i]) begin
      bus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat);
      check($sformatf("vec%0d_latency", i), lat, 1);
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end
    cur_div = 4;

    // Exact waveform of 0x55 at DIV=4.
    sb_q.push_back(8'h55);
    bus(A_TX, 32'h55, 4'b0001, rd, lat);
    check("tx55_latency", lat, 1);
    check("tx55_idle_before", {31'd0, uart_tx}, 32'd1);
    for (int i = 0; i < 44; i++) begin
      logic [7:0] pat;
      logic       e;
      pat = 8'h55;
      @(negedge clk);
      if (i < 4)       e = 1'b0;
      else if (i < 36) e = pat[(i - 4) / 4];
      else             e = 1'b1;
      check($sformatf("tx55_wave_c%0d", i), {31'd0, uart_tx}, {31'd0, e});
    end
    wait_drain(200);

    // Ten writes at DIV=100: one goes straight to the shifter, eight fill the FIFO, the last stalls.
    bus(A_DIV, 32'd100, 4'b0011, rd, lat);
    cur_div = 100;
    starts.delete();
    stall_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      b = 8'(i * 37 + 11);
      sb_q.push_back(b);
      bus(A_TX, {24'd0, b}, 4'b0001, rd, lat);
      if (i < 9) check($sformatf("fill%0d_latency", i), lat, 1);
      else begin
        check("full_write_stalled", {31'd0, lat > 500}, 32'd1);
        stall_cyc = cyc;
      end
      if (i == 3) begin
        bus(A_ST, 32'h0, 4'b0000, rd, lat);
        check("status_busy_count3", rd, 32'h8000_000C);
      end
    end
    wait_drain(12000);
    check("frame_count", starts.size(), 10);
    if (starts.size() == 10) begin
      check("stall_release_at_pop", starts[1], stall_cyc);
      for (int k = 1; k < 10; k++) check($sformatf("b2b_gap%0d", k), starts[k] - starts[k-1], 1000);
    end

    // Reset during data bit 3 at DIV=4 abandons the frame and empties the FIFO.
    bus(A_DIV, 32'd4, 4'b0011, rd, lat);
    cur_div = 4;
    mon_en = 1'b0;
    bus(A_TX, 32'hA5, 4'b0001, rd, lat);
    bus(A_TX, 32'h3C, 4'b0001, rd, lat);
    repeat (16) @(negedge clk);
    check("pre_reset_bit3", {31'd0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("reset_tx_immediate", {31'd0, uart_tx}, 32'd1);
    check("reset_ready_low", {31'd0, mem_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("reset_tx_hold", {31'd0, uart_tx}, 32'd1);
    rst_n = 1'b1;
    cur_div = 16;
    mon_en = 1'b1;
    bus(A_ST, 32'h0, 4'b0000, rd, lat);
    check("post_reset_status", rd, 32'h0000_0002);
    bus(A_DIV, 32'h0, 4'b0000, rd, lat);
    check("post_reset_div", rd, 32'h0000_0010);
    repeat (40) @(negedge clk);
    check("post_reset_line_idle", {31'd0, uart_tx}, 32'd1);

`ifdef MMIO_UART_TX_IRQ_EN
    // Interrupt on drain.
    bus(A_IRQ, 32'h1, 4'b0001, rd, lat);
    @(negedge clk);
    check("irq_idle_enabled", {31'd0, irq}, 32'd1);
    sb_q.push_back(8'h81);
    bus(A_TX, 32'h81, 4'b0001, rd, lat);
    @(negedge clk);
    check("irq_drop_on_write", {31'd0, irq}, 32'd0);
    check("irq_frame_start", {31'd0, uart_tx}, 32'd0);
    repeat (159) @(negedge clk);
    check("irq_low_in_stop", {31'd0, irq}, 32'd0);
    check("irq_stop_level", {31'd0, uart_tx}, 32'd1);
    repeat (2) @(negedge clk);
    check("irq_after_stop", {31'd0, irq}, 32'd1);
    wait_drain(100);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
